// File: rtl/cr_kme_arb_pkg.sv
// Shared types and helpers for the KME FIFO arbiter.
// Round-robin search is sized for up to eight requesters.
package cr_kme_arb_pkg;

    localparam logic IDLE  = 1'b0;
    localparam logic LOCK  = 1'b1;
    localparam int   CNT_W = 8;
    localparam int   IDX_W = 3;

    // First set bit of v at or after ptr, wrapping inside n entries.
    // Result is {found, index}.
    function automatic logic [IDX_W:0] rr_first(
        logic [7:0]       v,
        logic [IDX_W-1:0] ptr,
        int               n
    );
        logic [IDX_W:0] r;
        int             j;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (k < n && !r[IDX_W] && v[j[2:0]])
                r = {1'b1, j[2:0]};
        end
        return r;
    endfunction

    // Index following i, wrapping to zero after n-1.
    function automatic logic [IDX_W-1:0] rr_inc(
        logic [IDX_W-1:0] i,
        int               n
    );
        if (int'(i) >= n - 1) return '0;
        return i + 3'd1;
    endfunction

endpackage

// File: rtl/cr_kme_rr_pick.sv
// Combinational round-robin picker: valid vector plus pointer
// gives a one-hot grant and its index.
module cr_kme_rr_pick
    import cr_kme_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [7:0]     v8;
    logic [IDX_W:0] hit;

    // Search from the pointer and expand the hit into a one-hot grant.
    always_comb begin
        v8 = '0;
        v8[N_REQ-1:0] = valid_i;
        hit = rr_first(v8, ptr_i, N_REQ);
        any_o = hit[IDX_W];
        idx_o = hit[IDX_W-1:0];
        for (int i = 0; i < N_REQ; i++)
            gnt_o[i] = hit[IDX_W] && (hit[IDX_W-1:0] == IDX_W'(i));
    end

endmodule

// File: rtl/cr_kme_fifo_arb.sv
// Packet-atomic round-robin arbiter in front of the KME
// staging FIFO write port, with idle timeout and error latch.
module cr_kme_fifo_arb
    import cr_kme_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 96,
    parameter int TMO   = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ-1:0]    req_eop,
    output logic [N_REQ-1:0]    req_ack,
    output logic [DW-1:0]       fifo_in,
    output logic                fifo_in_valid,
    input  logic                fifo_in_stall,
    input  logic                fifo_overflow,
    input  logic                fifo_underflow,
    output logic                busy,
    output logic [2:0]          owner,
    output logic                tmo_err,
    output logic                fifo_err
);

    localparam logic             TMO_EN  = (TMO != 0);
    localparam logic [CNT_W-1:0] CNT_LIM =
        (TMO == 0) ? {CNT_W{1'b1}} : CNT_W'(TMO);

    logic             state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             ferr_q, ferr_d;

    logic [7:0]       vld8, eop8;
    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx, sel_idx;
    logic             pick_any, sel_vld, xfer;

    cr_kme_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Select the owner while locked, else the round-robin winner.
    always_comb begin
        vld8 = '0;
        eop8 = '0;
        vld8[N_REQ-1:0] = req_valid;
        eop8[N_REQ-1:0] = req_eop;
        sel_idx = (state_q == LOCK) ? owner_q : pick_idx;
        sel_vld = (state_q == LOCK) ? vld8[owner_q] : pick_any;
        xfer = sel_vld && !fifo_in_stall && !rst;
        for (int i = 0; i < N_REQ; i++)
            req_ack[i] = xfer && ((state_q == LOCK)
                ? (owner_q == IDX_W'(i)) : pick_gnt[i]);
        fifo_in_valid = xfer;
        fifo_in = req_data[int'(sel_idx)*DW +: DW];
    end

    // Lock, pointer, idle counter and error next-state.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        ferr_d  = ferr_q | fifo_overflow | fifo_underflow;
        if (state_q == IDLE) begin
            if (xfer) begin
                owner_d = sel_idx;
                if (eop8[sel_idx]) begin
                    rr_d = rr_inc(sel_idx, N_REQ);
                end else begin
                    state_d = LOCK;
                    cnt_d   = '0;
                end
            end
        end else if (xfer) begin
            cnt_d = '0;
            if (eop8[owner_q]) begin
                state_d = IDLE;
                rr_d    = rr_inc(owner_q, N_REQ);
            end
        end else if (TMO_EN && cnt_q == CNT_LIM
                     && !vld8[owner_q]) begin
            tmo_d   = 1'b1;
            state_d = IDLE;
            rr_d    = rr_inc(owner_q, N_REQ);
            cnt_d   = '0;
        end else if (cnt_q != CNT_LIM) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            ferr_q  <= ferr_d;
        end
    end

    assign busy     = (state_q == LOCK);
    assign owner    = owner_q;
    assign tmo_err  = tmo_q;
    assign fifo_err = ferr_q;

endmodule
